ritc_lane_align_ctrl: RTL and testbench

- Parametrised register-mapped control block for the RITC input datapath, in the user_clk_i domain.
- Owns datapath disable/reset and per-lane manual bitslip.
- Adds an automatic training state machine: walks every lane (NCH channels x NBIT bits), compares the deserialised word against a training pattern, and issues bitslips until lock or failure.
- Publishes a per-lane lock bitmap and status for software.

---
 rtl/ritc_lane_align_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_ritc_lane_align_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ritc_lane_align_ctrl.sv
// RITC input datapath control: disable/reset, manual bitslip and automatic per-lane training.
// Optional debug bus enabled with RITC_ALIGN_DEBUG_EN.
module ritc_lane_align_ctrl #(
  parameter int unsigned NCH           = 6,
  parameter int unsigned NBIT          = 12,
  parameter int unsigned SER_W         = 8,
  parameter logic [SER_W-1:0] TRAIN_PATTERN = 8'hB4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned MATCH_N       = 4
) (
  input  logic                  user_clk_i,
  input  logic                  user_rst_n_i,
  input  logic                  user_sel_i,
  input  logic [3:0]            user_addr_i,
  input  logic                  user_wr_i,
  input  logic                  user_rd_i,
  input  logic [31:0]           user_dat_i,
  output logic [31:0]           user_dat_o,
  input  logic [SER_W-1:0]      lane_word_i,
  output logic [6:0]            lane_sel_o,
  output logic [NCH*NBIT-1:0]   bitslip_o,
  output logic                  datapath_disable_o,
  output logic                  datapath_reset_o,
  output logic                  busy_o,
  output logic [31:0]           debug_o
);

  localparam int unsigned NLANE = NCH * NBIT;
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned MC_W  = $clog2(MATCH_N + 1);
  localparam int unsigned SL_W  = 4;
  localparam logic [6:0]  LAST_LANE = 7'(NLANE - 1);
  localparam logic [7:0]  NLANE_L   = 8'(NLANE);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    SETTLE  = 3'd2,
    COMPARE = 3'd3,
    SLIP    = 3'd4,
    NEXT    = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [6:0]         lane_q, lane_d;
  logic [SL_W-1:0]    slip_q, slip_d;
  logic [MC_W-1:0]    match_q, match_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [NLANE-1:0]   lock_q, lock_d;
  logic [7:0]         fail_q, fail_d;
  logic               done_q, done_d;
  logic               all_locked_q, all_locked_d;
  logic [NLANE-1:0]   bitslip_d;
  logic [127:0]       lock_pad;
  logic [31:0]        rdata_c;
  logic               wr0_c, wr1_c, rd_c, busy_c, start_c, abort_c, man_slip_c;
  logic               unused_dat;

  // Register strobes; a reset request outranks a start written in the same word
  assign wr0_c      = user_sel_i & user_wr_i & (user_addr_i == 4'h0);
  assign wr1_c      = user_sel_i & user_wr_i & (user_addr_i == 4'h1);
  assign rd_c       = user_sel_i & user_rd_i;
  assign busy_c     = (state_q != IDLE) && (state_q != DONE);
  assign start_c    = wr0_c & user_dat_i[2] & ~user_dat_i[1] & ~user_dat_i[0];
  assign abort_c    = wr0_c & busy_c & (user_dat_i[0] | user_dat_i[1]);
  assign man_slip_c = wr1_c & user_dat_i[31] & ~busy_c & ({1'b0, user_dat_i[6:0]} < NLANE_L);
  assign unused_dat = ^user_dat_i[30:7];
  assign lock_pad   = 128'(lock_q);

  // Training sequencer: next state and datapath updates
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    slip_d       = slip_q;
    match_d      = match_q;
    settle_d     = settle_q;
    lock_d       = lock_q;
    fail_d       = fail_q;
    done_d       = done_q;
    all_locked_d = all_locked_q;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d      = SELECT;
          lane_d       = '0;
          lock_d       = '0;
          fail_d       = '0;
          done_d       = 1'b0;
          all_locked_d = 1'b0;
        end
      end
      SELECT: begin
        slip_d   = '0;
        match_d  = '0;
        settle_d = SET_W'(SETTLE_CYCLES);
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q <= SET_W'(1)) state_d = COMPARE;
        else                       settle_d = settle_q - SET_W'(1);
      end
      COMPARE: begin
        if (lane_word_i == TRAIN_PATTERN) begin
          if (match_q == MC_W'(MATCH_N - 1)) begin
            lock_d[lane_q] = 1'b1;
            state_d        = NEXT;
          end else begin
            match_d = match_q + MC_W'(1);
          end
        end else begin
          match_d = '0;
          if (slip_q == SL_W'(SER_W - 1)) begin
            if (fail_q != 8'hFF) fail_d = fail_q + 8'd1;
            state_d = NEXT;
          end else begin
            state_d = SLIP;
          end
        end
      end
      SLIP: begin
        slip_d   = slip_q + SL_W'(1);
        settle_d = SET_W'(SETTLE_CYCLES);
        state_d  = SETTLE;
      end
      NEXT: begin
        if (lane_q == LAST_LANE) begin
          state_d = DONE;
        end else begin
          lane_d  = lane_q + 7'd1;
          state_d = SELECT;
        end
      end
      DONE: begin
        done_d       = 1'b1;
        all_locked_d = &lock_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort_c) state_d = IDLE;
  end

  // Slip pulse follows the SLIP state; aborting out of a pending SLIP drops it
  always_comb begin
    bitslip_d = '0;
    if (state_d == SLIP)  bitslip_d[lane_d] = 1'b1;
    else if (man_slip_c)  bitslip_d[user_dat_i[6:0]] = 1'b1;
  end

  always_comb begin
    rdata_c = '0;
    case (user_addr_i)
      4'h0: rdata_c = 32'(datapath_disable_o);
      4'h2: rdata_c = {9'd0, lane_q, fail_q, 5'd0, all_locked_q, done_q, busy_c};
      4'h4, 4'h5, 4'h6, 4'h7: rdata_c = lock_pad[{user_addr_i[1:0], 5'd0} +: 32];
      default: rdata_c = '0;
    endcase
  end

  always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
    if (!user_rst_n_i) begin
      state_q      <= IDLE;
      lane_q       <= '0;
      slip_q       <= '0;
      match_q      <= '0;
      settle_q     <= '0;
      lock_q       <= '0;
      fail_q       <= '0;
      done_q       <= 1'b0;
      all_locked_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      slip_q       <= slip_d;
      match_q      <= match_d;
      settle_q     <= settle_d;
      lock_q       <= lock_d;
      fail_q       <= fail_d;
      done_q       <= done_d;
      all_locked_q <= all_locked_d;
    end
  end

  // Registered outputs
  always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
    if (!user_rst_n_i) begin
      user_dat_o         <= '0;
      lane_sel_o         <= '0;
      bitslip_o          <= '0;
      datapath_disable_o <= 1'b1;
      datapath_reset_o   <= 1'b0;
      busy_o             <= 1'b0;
    end else begin
      user_dat_o         <= rd_c ? rdata_c : 32'd0;
      lane_sel_o         <= lane_d;
      bitslip_o          <= bitslip_d;
      datapath_reset_o   <= wr0_c & user_dat_i[1];
      busy_o             <= (state_d != IDLE) && (state_d != DONE);
      if (wr0_c) datapath_disable_o <= user_dat_i[0];
    end
  end

`ifdef RITC_ALIGN_DEBUG_EN
  always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
    if (!user_rst_n_i) begin
      debug_o <= '0;
    end else begin
      debug_o <= {3'(state_q), lane_q, 4'(slip_q), 4'(match_q), 8'(lane_word_i),
                  |bitslip_o, busy_o, datapath_reset_o, datapath_disable_o, 2'b00};
    end
  end
`else
  assign debug_o = '0;
`endif

endmodule

// File: tb/tb_ritc_lane_align_ctrl.sv
// Scoreboard bench for ritc_lane_align_ctrl with a behavioural lane model driving lane_word_i.
module tb_ritc_lane_align_ctrl;

  localparam int NLANE = 72;
  localparam int NEVER = -1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdat = '0;
  logic [31:0] rdat;
  logic [7:0]  lane_word;
  logic [6:0]  lane_sel;
  logic [NLANE-1:0] bitslip;
  logic        dp_disable, dp_reset, busy;
  logic [31:0] debug;

  int checks = 0;
  int errors = 0;

  int req_slips [NLANE];
  int seen_slips[NLANE];
  int total_slips, long_pulses, multi_hot, reset_pulses;
  int cyc, last5, gap5;
  logic [NLANE-1:0] prev_bs;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        rd_pend = 1'b0;

  ritc_lane_align_ctrl dut (
    .user_clk_i         (clk),
    .user_rst_n_i       (rst_n),
    .user_sel_i         (sel),
    .user_addr_i        (addr),
    .user_wr_i          (wr),
    .user_rd_i          (rd),
    .user_dat_i         (wdat),
    .user_dat_o         (rdat),
    .lane_word_i        (lane_word),
    .lane_sel_o         (lane_sel),
    .bitslip_o          (bitslip),
    .datapath_disable_o (dp_disable),
    .datapath_reset_o   (dp_reset),
    .busy_o             (busy),
    .debug_o            (debug)
  );

  always #5 clk = ~clk;

  // Lane model: aligned word once the lane has seen its required number of slips
  always_comb begin
    lane_word = 8'h4B;
    if (int'(lane_sel) < NLANE && seen_slips[int'(lane_sel)] == req_slips[int'(lane_sel)])
      lane_word = 8'hB4;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) rd_pend <= sel & rd;

  // Read scoreboard: pop expected value when registered read data is presented
  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else check(tag_q.pop_front(), rdat, exp_q.pop_front());
    end
  end

  // Pulse monitor
  always @(negedge clk) begin
    cyc++;
    if (bitslip != '0 && prev_bs != '0) long_pulses++;
    if (!$onehot0(bitslip)) multi_hot++;
    for (int i = 0; i < NLANE; i++) begin
      if (bitslip[i]) begin
        seen_slips[i]++;
        total_slips++;
      end
    end
    if (bitslip[5]) begin
      if (cyc - last5 < gap5) gap5 = cyc - last5;
      last5 = cyc;
    end
    if (dp_reset) reset_pulses++;
    prev_bs = bitslip;
  end

  task automatic clear_counts();
    for (int i = 0; i < NLANE; i++) seen_slips[i] = 0;
    total_slips = 0; long_pulses = 0; reset_pulses = 0;
    last5 = -100000; gap5 = 1000000;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    sel = 1'b1; wr = 1'b1; addr = a; wdat = d;
    @(posedge clk); #1;
    sel = 1'b0; wr = 1'b0; wdat = '0;
  endtask

  task automatic rd_reg(input logic [3:0] a, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk); #1;
    sel = 1'b1; rd = 1'b1; addr = a;
    @(posedge clk); #1;
    sel = 1'b0; rd = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < NLANE; i++) req_slips[i] = 0;
    cyc = 0; multi_hot = 0; prev_bs = '0;
    clear_counts();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check("rst_disable", 32'(dp_disable), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rd_reg(4'h0, 32'h1, "rd_ctrl_rst");
    rd_reg(4'h2, 32'h0, "rd_status_rst");

    // Start while disabled is ignored
    wr_reg(4'h0, 32'h5);
    repeat (3) @(posedge clk); #1;
    check("start_disabled_busy", 32'(busy), 32'd0);
    wr_reg(4'h0, 32'h0);
    check("enable", 32'(dp_disable), 32'd0);

    // Run 1: every lane aligned without slips
    clear_counts();
    wr_reg(4'h0, 32'h4);
    check("run1_busy", 32'(busy), 32'd1);
    n = 0;
    while (lane_sel != 7'd1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("lane0_latency", 32'(n), 32'd22);
    wait_idle("run1_timeout");
    check("run1_slips", 32'(total_slips), 32'd0);
    rd_reg(4'h2, 32'h0047_0006, "run1_status");
    rd_reg(4'h4, 32'hFFFF_FFFF, "run1_lock0");
    rd_reg(4'h5, 32'hFFFF_FFFF, "run1_lock1");
    rd_reg(4'h6, 32'h0000_00FF, "run1_lock2");
    rd_reg(4'h7, 32'h0000_0000, "run1_lock3");

    // Run 2: lane 5 needs three slips
    clear_counts();
    req_slips[5] = 3;
    wr_reg(4'h0, 32'h4);
    wait_idle("run2_timeout");
    check("run2_lane5_slips", 32'(seen_slips[5]), 32'd3);
    check("run2_total_slips", 32'(total_slips), 32'd3);
    check("run2_gap_ok", 32'(gap5 >= 17), 32'd1);
    check("run2_pulse_width", 32'(long_pulses), 32'd0);
    rd_reg(4'h4, 32'hFFFF_FFFF, "run2_lock0");
    rd_reg(4'h2, 32'h0047_0006, "run2_status");

    // Run 3: lane 70 never matches
    clear_counts();
    req_slips[5] = 0;
    req_slips[70] = NEVER;
    wr_reg(4'h0, 32'h4);
    wait_idle("run3_timeout");
    check("run3_lane70_slips", 32'(seen_slips[70]), 32'd7);
    check("run3_total_slips", 32'(total_slips), 32'd7);
    rd_reg(4'h2, 32'h0047_0102, "run3_status");
    rd_reg(4'h6, 32'h0000_00BF, "run3_lock2");
    req_slips[70] = 0;

    // Run 4: datapath reset during SETTLE of lane 10
    clear_counts();
    wr_reg(4'h0, 32'h4);
    n = 0;
    while (lane_sel != 7'd10 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_lane10", 32'(lane_sel), 32'd10);
    repeat (3) @(posedge clk); #1;
    wr_reg(4'h0, 32'h2);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (20) @(posedge clk); #1;
    check("abort_busy_late", 32'(busy), 32'd0);
    check("abort_reset_pulses", 32'(reset_pulses), 32'd1);
    check("abort_slips", 32'(total_slips), 32'd0);
    rd_reg(4'h2, 32'h000A_0000, "abort_status");
    rd_reg(4'h4, 32'h0000_03FF, "abort_lock0");
    rd_reg(4'h5, 32'h0000_0000, "abort_lock1");

    // Manual bitslip: idle, busy, out of range
    clear_counts();
    wr_reg(4'h1, 32'h8000_000C);
    repeat (3) @(posedge clk); #1;
    check("man_slip12", 32'(seen_slips[12]), 32'd1);
    check("man_slip_total", 32'(total_slips), 32'd1);
    check("man_slip_width", 32'(long_pulses), 32'd0);
    clear_counts();
    wr_reg(4'h0, 32'h4);
    wr_reg(4'h1, 32'h8000_000C);
    repeat (3) @(posedge clk); #1;
    check("man_slip_busy", 32'(total_slips), 32'd0);
    wr_reg(4'h0, 32'h1);
    check("disable_abort_busy", 32'(busy), 32'd0);
    wr_reg(4'h0, 32'h0);
    wr_reg(4'h1, 32'h8000_007F);
    repeat (3) @(posedge clk); #1;
    check("man_slip_oob", 32'(total_slips), 32'd0);
    rd_reg(4'h2, 32'h0000_0000, "abort2_status");

    // Asynchronous reset mid-run
    wr_reg(4'h0, 32'h4);
    repeat (30) @(posedge clk); #1;
    check("midrun_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_disable", 32'(dp_disable), 32'd1);
    check("arst_reset", 32'(dp_reset), 32'd0);
    check("arst_lane_sel", 32'(lane_sel), 32'd0);
    check("arst_bitslip", 32'(bitslip != '0), 32'd0);
    check("arst_dat", rdat, 32'd0);
    check("arst_debug", debug, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd_reg(4'h0, 32'h1, "rd_ctrl_after_rst");
    rd_reg(4'h2, 32'h0, "rd_status_after_rst");

    check("never_multi_hot", 32'(multi_hot), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
